uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that drains bytes from the read port of a `sync_fifo`, acting as that FIFO's consumer. It sits between the core's memory-mapped UART register block and the `tx` pin. Software pushes bytes into the FIFO. This block pops one entry per frame and serialises it as start bit, data LSB-first, optional parity, and stop bit(s). It keeps transmitting back-to-back while the FIFO is non-empty and `en_i` is high.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..9.
- `PARITY_EN`, default 0: 1 adds a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.
- `DIV_W`, default 16: width of the baud divisor.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: transmit enable. Sampled only in IDLE.
- `baud_div_i`, in, DIV_W: cycles per bit minus 1. Latched at frame start.
- `fifo_empty_i`, in, 1: FIFO empty flag.
- `fifo_data_i`, in, DATA_BITS: FIFO head entry. Combinational and valid whenever not empty.
- `fifo_rd_o`, out, 1: pop strobe. At most one cycle per frame.
- `tx_o`, out, 1: serial line. Registered, idles high.
- `busy_o`, out, 1: high whenever state is not IDLE.

## Operation
- States and transitions:
  - IDLE → START on the pop condition.
  - START → DATA.
  - DATA → PARITY, or → STOP when `PARITY_EN`=0.
  - PARITY → STOP.
  - STOP → IDLE.
- Pop condition: state==IDLE && `en_i` && !`fifo_empty_i`.
- `fifo_rd_o` is combinational and equals the pop condition gated by !`rst_i`.
- On the pop edge, the block does all of the following:
  - captures `fifo_data_i` into the shift register;
  - captures `baud_div_i` into the divisor register;
  - computes parity from the captured data;
  - loads the bit counter with 0;
  - loads the baud counter with the divisor.
- Baud counter:
  - decrements every cycle;
  - a bit ends on the cycle where the count is 0, which reloads the counter from the latched divisor.
- Each bit is therefore held exactly D+1 cycles, where D is the latched divisor. D=0 is legal and gives 1 cycle per bit.
- DATA state:
  - `tx_o` = shift[0];
  - at each bit end, shift right and increment the bit counter;
  - leave after bit index DATA_BITS-1.
- Parity bit value:
  - even parity: XOR of the data bits;
  - odd parity: inverted XOR.
- STOP state:
  - `tx_o`=1 for STOP_BITS×(D+1) cycles;
  - the bit counter is reused to count stop bits.
- Changes to `baud_div_i` or `en_i` mid-frame have no effect on the current frame.
- Deasserting `en_i` lets the current frame finish, then no further pop occurs.
- `fifo_data_i` is ignored outside the pop cycle.

## Timing
- Reset values: state IDLE, `tx_o`=1, `busy_o`=0, `fifo_rd_o`=0, all counters 0.
- Reset applied mid-frame:
  - the next cycle has `tx_o`=1 and `busy_o`=0;
  - the partial frame is abandoned;
  - the popped entry is not re-read.
- Pop in cycle T:
  - `tx_o` falls at T+1;
  - `busy_o` rises at T+1.
- Frame length: F = (1 + DATA_BITS + PARITY_EN + STOP_BITS)×(D+1) cycles, counted from T+1.
- Last stop cycle is T+F. The state is IDLE at T+F+1, and a new pop may occur in that cycle.
- Back-to-back frames: the next start bit begins at T+F+2. This one-cycle idle-high gap is required and fixed.
- Pop occurring with the FIFO at 1 entry: `fifo_empty_i` rises the following cycle, and no second pop follows.
- A FIFO write while the block is in IDLE with the FIFO empty:
  - `fifo_empty_i` falls the next cycle;
  - the pop happens in that cycle if `en_i` is high.

## Structure
- `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `DEFAULT_BAUD_DIV` (e.g. 50 MHz/115200 − 1 = 433);
  - the frame-length helper function used by the bench.
- Sub-module `uart_baud_gen`:
  - loadable down-counter with ports `load`, `div`, and a `tick` output;
  - shared later with `uart_rx`.
- The FSM, shift register and parity logic live in `uart_tx`.

## Test plan
- Single byte, default params:
  - stimulus: D=3, FIFO holds 0xA5;
  - `fifo_rd_o` high for exactly 1 cycle;
  - `tx_o` sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1;
  - `busy_o` high for 40 cycles.
- Back-to-back frames:
  - stimulus: FIFO holds 0x00, 0xFF, 0x55, D=0;
  - three frames of 10 cycles each, separated by a single idle-high cycle;
  - exactly 3 pops;
  - `busy_o` low after the last frame.
- Parity and stop-bit variants:
  - stimulus: `PARITY_EN`=1, `PARITY_ODD`=0, `STOP_BITS`=2, byte 0x07, D=1;
  - parity bit = 1;
  - frame is 24 cycles;
  - stop segment is 4 cycles high.
- Mid-frame changes:
  - stimulus: change `baud_div_i` from 3 to 7 and drop `en_i` during the DATA state of frame 1, with the FIFO still non-empty;
  - frame 1 completes at 4 cycles per bit;
  - no second pop occurs;
  - `tx_o` stays high.
- Reset mid-frame:
  - stimulus: assert `rst_i` for 1 cycle during bit 3;
  - next cycle has `tx_o`=1 and `busy_o`=0;
  - after release, the next FIFO entry (not the aborted one) is sent.
- Empty-then-write:
  - stimulus: write 0x3C into an empty FIFO while `en_i`=1;
  - pop occurs in the cycle after the write;
  - start bit begins on the following cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter types, constants and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    localparam int DEFAULT_BAUD_DIV = 433;
    localparam int BIT_CNT_W        = 4;

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frameCycles(input int dataBits, input int parityEn,
                                       input int stopBits, input int baudDiv);
        return (1 + dataBits + parityEn + stopBits) * (baudDiv + 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter: tick marks the last cycle of each bit period.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_div   <= div;
            r_count <= div;
        end else if (r_count == '0) begin
            r_count <= r_div;
        end else begin
            r_count <= r_count - DIV_W'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a sync_fifo: start bit, data LSB-first, optional parity, stop bit(s).
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_W-1:0]     baud_div_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_BITS-1:0] fifo_data_i,
    output logic                 fifo_rd_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    uart_tx_state_t       r_state;
    uart_tx_state_t       w_stateNext;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic [BIT_CNT_W-1:0] r_bitCnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 w_txNext;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_lastData;
    logic                 w_lastStop;

    assign w_pop      = (r_state == IDLE) && en_i && !fifo_empty_i;
    assign fifo_rd_o  = w_pop && !rst_i;
    assign w_lastData = (r_bitCnt == BIT_CNT_W'(DATA_BITS - 1));
    assign w_lastStop = (r_bitCnt == BIT_CNT_W'(STOP_BITS - 1));
    assign tx_o       = r_tx;
    assign busy_o     = (r_state != IDLE);

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (w_pop),
        .div   (baud_div_i),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_tx    <= w_txNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_stateNext = START;
            START:   if (w_tick) w_stateNext = DATA;
            DATA:    if (w_tick && w_lastData) w_stateNext = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (w_tick) w_stateNext = STOP;
            STOP:    if (w_tick && w_lastStop) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // tx is registered, so it is driven from the state and shift value about to be entered.
    always_comb begin
        w_txNext = 1'b1;
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            PARITY:  w_txNext = r_parity;
            default: w_txNext = 1'b1;
        endcase
    end

    assign w_shiftNext = w_pop ? fifo_data_i
                       : ((r_state == DATA) && w_tick) ? (r_shift >> 1)
                       : r_shift;

    // The bit counter indexes data bits, then is reused to count stop bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_parity <= 1'b0;
        end else begin
            r_shift <= w_shiftNext;
            if (w_pop) begin
                r_bitCnt <= '0;
                r_parity <= (^fifo_data_i) ^ (PARITY_ODD != 0);
            end else if (w_tick) begin
                if (r_state == DATA) begin
                    r_bitCnt <= w_lastData ? '0 : r_bitCnt + BIT_CNT_W'(1);
                end else if (r_state == STOP) begin
                    r_bitCnt <= w_lastStop ? '0 : r_bitCnt + BIT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a default 8N1 instance and an 8E2 instance, each fed by a queue FIFO model.
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [9:0] frame;
        int         busyCycles;
    } vecRecT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, en1;
    logic [15:0] div0, div1;
    logic        empty0 = 1'b1;
    logic        empty1 = 1'b1;
    logic [7:0]  data0 = 8'h00;
    logic [7:0]  data1 = 8'h00;
    logic        rd0, rd1, tx0, tx1, busy0, busy1;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  burstBytes[$];
    logic        capTx[$];
    logic        capBusy[$];
    logic        capRd[$];
    logic        expTx[$];
    vecRecT      vecs[5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en0),
        .baud_div_i   (div0),
        .fifo_empty_i (empty0),
        .fifo_data_i  (data0),
        .fifo_rd_o    (rd0),
        .tx_o         (tx0),
        .busy_o       (busy0)
    );

    uart_tx #(
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (2)
    ) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en1),
        .baud_div_i   (div1),
        .fifo_empty_i (empty1),
        .fifo_data_i  (data1),
        .fifo_rd_o    (rd1),
        .tx_o         (tx1),
        .busy_o       (busy1)
    );

    // FIFO models: a write becomes visible after the next clock edge, a pop removes the head at the edge.
    always @(posedge clk) begin
        if (rd0 && q0.size() > 0) void'(q0.pop_front());
        empty0 <= (q0.size() == 0);
        data0  <= (q0.size() > 0) ? q0[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (rd1 && q1.size() > 0) void'(q1.pop_front());
        empty1 <= (q1.size() == 0);
        data1  <= (q1.size() > 0) ? q1[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic enVal, input int divVal);
        if (sel == 0) begin
            en0  = enVal;
            div0 = 16'(divVal);
        end else begin
            en1  = enVal;
            div1 = 16'(divVal);
        end
    endtask

    task automatic pushByte(input int sel, input logic [7:0] b);
        if (sel == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic capture(input int sel, input int n);
        capTx.delete();
        capBusy.delete();
        capRd.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            capTx.push_back((sel == 1) ? tx1 : tx0);
            capBusy.push_back((sel == 1) ? busy1 : busy0);
            capRd.push_back((sel == 1) ? rd1 : rd0);
        end
    endtask

    // Reference line waveform for one frame, built from the bit list of the frame format.
    task automatic modelFrame(input int sel, input logic [7:0] data, input int d);
        int bits[$];
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back(int'(data[i]));
        if (sel == 1) bits.push_back($countones(data) % 2);
        repeat ((sel == 1) ? 2 : 1) bits.push_back(1);
        foreach (bits[b]) repeat (d + 1) expTx.push_back(bits[b] != 0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWave(input string name, input int start);
        int bad = -1;
        for (int i = 0; i < expTx.size(); i++) begin
            if (capTx[start + i] !== expTx[i]) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s: tx at cycle %0d got %b, expected %b",
                     name, start + bad, capTx[start + bad], expTx[bad]);
        end
    endtask

    task automatic checkPops(input string name, input int nb, input int step);
        int cnt = 0;
        int bad = -1;
        foreach (capRd[i]) begin
            if (capRd[i] === 1'b1) begin
                if (bad < 0 && i != cnt * step) bad = i;
                cnt++;
            end
        end
        checkOutput({name, " pop count"}, cnt, nb);
        checkOutput({name, " misplaced pop cycle"}, bad, -1);
    endtask

    function automatic int sumBusy();
        int s = 0;
        foreach (capBusy[i]) if (capBusy[i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int countRd();
        int s = 0;
        foreach (capRd[i]) if (capRd[i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int firstRd();
        foreach (capRd[i]) if (capRd[i] === 1'b1) return i;
        return -1;
    endfunction

    // Queue burstBytes with en low, then enable and check back-to-back frames against the model.
    task automatic runBurst(input int sel, input int d, input string name);
        int nb, f, step;
        nb   = burstBytes.size();
        f    = frameCycles(8, sel, (sel == 1) ? 2 : 1, d);
        step = f + 1;
        tick();
        applyStimulus(sel, 1'b0, d);
        foreach (burstBytes[k]) pushByte(sel, burstBytes[k]);
        tick();
        tick();
        applyStimulus(sel, 1'b1, d);
        capture(sel, nb * step + 4);
        expTx.delete();
        foreach (burstBytes[k]) begin
            modelFrame(sel, burstBytes[k], d);
            expTx.push_back(1'b1);
        end
        checkWave({name, " wave"}, 1);
        checkPops(name, nb, step);
        checkOutput({name, " busy cycles"}, sumBusy(), nb * f);
        checkBit({name, " busy after"}, capBusy[nb * step], 1'b0);
        tick();
        applyStimulus(sel, 1'b0, d);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3, 10'b1101001010, 40};
        vecs[1] = '{8'h00, 0, 10'b1000000000, 10};
        vecs[2] = '{8'hFF, 1, 10'b1111111110, 20};
        vecs[3] = '{8'h55, 2, 10'b1010101010, 30};
        vecs[4] = '{8'h3C, 0, 10'b1001111000, 10};

        rst = 1'b1;
        applyStimulus(0, 1'b0, 0);
        applyStimulus(1, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBit("reset tx0", tx0, 1'b1);
        checkBit("reset busy0", busy0, 1'b0);
        checkBit("reset rd0", rd0, 1'b0);
        checkBit("reset tx1", tx1, 1'b1);
        checkBit("reset busy1", busy1, 1'b0);
        tick();
        rst = 1'b0;

        // Single frames written into an empty FIFO with en high: pop one cycle after the write.
        for (int v = 0; v < 5; v++) begin
            tick();
            applyStimulus(0, 1'b1, vecs[v].div);
            pushByte(0, vecs[v].data);
            capture(0, vecs[v].busyCycles + 4);
            checkOutput($sformatf("vec%0d pop cycle", v), firstRd(), 1);
            checkOutput($sformatf("vec%0d pop count", v), countRd(), 1);
            checkOutput($sformatf("vec%0d busy cycles", v), sumBusy(), vecs[v].busyCycles);
            begin
                int bad = -1;
                for (int i = 0; i < vecs[v].busyCycles; i++) begin
                    if (bad < 0 && capTx[2 + i] !== vecs[v].frame[i / (vecs[v].div + 1)]) bad = i;
                end
                checkOutput($sformatf("vec%0d first wrong tx cycle", v), bad, -1);
            end
            checkBit($sformatf("vec%0d idle busy", v), capBusy[vecs[v].busyCycles + 2], 1'b0);
            checkBit($sformatf("vec%0d idle tx", v), capTx[vecs[v].busyCycles + 2], 1'b1);
        end
        tick();
        applyStimulus(0, 1'b0, 0);

        burstBytes = '{8'h00, 8'hFF, 8'h55};
        runBurst(0, 0, "b2b");

        // Mid-frame divisor change and en drop with a second entry waiting.
        tick();
        applyStimulus(0, 1'b0, 3);
        pushByte(0, 8'h96);
        pushByte(0, 8'h81);
        tick();
        tick();
        applyStimulus(0, 1'b1, 3);
        fork
            capture(0, 60);
            begin
                repeat (14) tick();
                applyStimulus(0, 1'b0, 7);
            end
        join
        expTx.delete();
        modelFrame(0, 8'h96, 3);
        repeat (19) expTx.push_back(1'b1);
        checkWave("mid wave", 1);
        checkOutput("mid pop count", countRd(), 1);
        checkOutput("mid busy cycles", sumBusy(), 40);

        // Reset during data bit 3 of the 0x81 frame, then 0x5A must follow.
        tick();
        pushByte(0, 8'h5A);
        applyStimulus(0, 1'b0, 3);
        tick();
        tick();
        applyStimulus(0, 1'b1, 3);
        fork
            capture(0, 64);
            begin
                repeat (18) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        join
        expTx.delete();
        modelFrame(0, 8'h81, 3);
        while (expTx.size() > 18) void'(expTx.pop_back());
        expTx.push_back(1'b1);
        modelFrame(0, 8'h5A, 3);
        repeat (4) expTx.push_back(1'b1);
        checkBit("rst tx next", capTx[19], 1'b1);
        checkBit("rst busy next", capBusy[19], 1'b0);
        checkBit("rst repop", capRd[19], 1'b1);
        checkOutput("rst pop count", countRd(), 2);
        checkWave("rst wave", 1);
        tick();
        applyStimulus(0, 1'b0, 3);

        // Even parity, two stop bits, D=1.
        tick();
        applyStimulus(1, 1'b1, 1);
        pushByte(1, 8'h07);
        capture(1, 28);
        expTx.delete();
        modelFrame(1, 8'h07, 1);
        checkOutput("par pop cycle", firstRd(), 1);
        checkWave("par wave", 2);
        checkBit("par bit", capTx[20], 1'b1);
        checkOutput("par stop high cycles",
                    int'(capTx[22]) + int'(capTx[23]) + int'(capTx[24]) + int'(capTx[25]), 4);
        checkBit("par busy last stop", capBusy[25], 1'b1);
        checkBit("par busy after", capBusy[26], 1'b0);
        checkOutput("par busy cycles", sumBusy(), 24);
        tick();
        applyStimulus(1, 1'b0, 1);

        for (int r = 0; r < 6; r++) begin
            int nb;
            burstBytes.delete();
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) burstBytes.push_back(8'($urandom_range(0, 255)));
            runBurst(r % 2, $urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
